// File: rtl/blob_run_ctrl.sv
// blob_run_ctrl: per-frame sequencer for the blob-counting analyzer.
// Arms the analyzer, streams a thresholded frame from the SDRAM read FIFO,
// optionally triggers the size-categorization pass, and latches results.
// Optional feature macro: BLOB_CATEG_EN (adds the CATEG state, drives
// o_blob_switch and latches o_bigger/o_smaller).
module blob_run_ctrl #(
  parameter int IMG_COL     = 800,
  parameter int IMG_ROW     = 600,
  parameter int TIMEOUT_CYC = 2**20,
  parameter int CAT_WAIT    = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_thresh,
  input  logic       i_invert,
  input  logic       i_pix_valid,
  input  logic [7:0] i_pix_luma,
  output logic       o_rd_req,
  output logic       o_blob_valid,
  output logic       o_blob_seq,
  output logic       o_blob_switch,
  input  logic       i_blob_sdram_req,
  input  logic       i_blob_done,
  input  logic [7:0] i_blob_count,
  input  logic [7:0] i_blob_bigger,
  input  logic [7:0] i_blob_smaller,
  output logic [7:0] o_count,
  output logic [7:0] o_bigger,
  output logic [7:0] o_smaller,
  output logic       o_result_valid,
  output logic       o_busy,
  output logic [1:0] o_err
);

  localparam int               PIX_W    = 19;
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMG_COL * IMG_ROW - 1);
  localparam int               WD_W     = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_UNDERRUN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_STREAM,
    S_WAIT_RES,
`ifdef BLOB_CATEG_EN
    S_CATEG,
`endif
    S_LATCH,
    S_RELEASE
  } state_t;

  state_t           state_reg, state_next;
  logic [PIX_W-1:0] pix_cnt_reg;
  logic [WD_W-1:0]  wd_cnt_reg;
  logic [7:0]       thr_reg;
  logic             inv_reg;
  logic             underrun_reg;
  logic             seq_reg;
  logic [1:0]       err_reg;
  logic [7:0]       count_reg;
  logic [7:0]       bigger_reg;
  logic [7:0]       smaller_reg;
  logic             result_valid_reg;

  logic start_acc;
  logic timeout;
  logic latch_en;
  logic stream_bit;

`ifdef BLOB_CATEG_EN
  localparam int              CAT_W    = $clog2(CAT_WAIT + 1);
  localparam logic [CAT_W-1:0] CAT_LAST = CAT_W'(CAT_WAIT);
  logic [CAT_W-1:0] cat_cnt_reg;
`else
  // Large/small counts are not consumed without the categorize pass.
  logic unused_categ;
  assign unused_categ = ^{i_blob_bigger, i_blob_smaller};
`endif

  // State register; reset forces IDLE immediately, dropping valid/rd_req.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state decode plus single-cycle control strobes.
  always_comb begin
    state_next = state_reg;
    start_acc  = 1'b0;
    timeout    = 1'b0;
    latch_en   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (i_start) begin
          start_acc  = 1'b1;
          state_next = S_ARM;
        end
      end
      S_ARM: begin
        if (i_blob_sdram_req) begin
          state_next = S_STREAM;
        end else if (wd_cnt_reg == WD_LAST) begin
          timeout    = 1'b1;
          state_next = S_RELEASE;
        end
      end
      S_STREAM: begin
        if (pix_cnt_reg == PIX_LAST) state_next = S_WAIT_RES;
      end
      S_WAIT_RES: begin
        if (i_blob_done) begin
          if (underrun_reg) state_next = S_RELEASE;
`ifdef BLOB_CATEG_EN
          else              state_next = S_CATEG;
`else
          else              state_next = S_LATCH;
`endif
        end else if (wd_cnt_reg == WD_LAST) begin
          timeout    = 1'b1;
          state_next = S_RELEASE;
        end
      end
`ifdef BLOB_CATEG_EN
      S_CATEG: begin
        if (cat_cnt_reg == CAT_LAST) state_next = S_LATCH;
      end
`endif
      S_LATCH: begin
        latch_en   = 1'b1;
        state_next = S_RELEASE;
      end
      S_RELEASE: begin
        if (!i_blob_done) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pixel counter advances every STREAM cycle; the watchdog restarts on any state change.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pix_cnt_reg <= '0;
      wd_cnt_reg  <= '0;
    end else begin
      pix_cnt_reg <= (state_reg == S_STREAM) ? pix_cnt_reg + PIX_W'(1) : '0;
      if (state_next != state_reg)
        wd_cnt_reg <= '0;
      else if (state_reg == S_ARM || state_reg == S_WAIT_RES)
        wd_cnt_reg <= wd_cnt_reg + WD_W'(1);
      else
        wd_cnt_reg <= '0;
    end
  end

`ifdef BLOB_CATEG_EN
  // Categorize wait counter: cycle 0 carries the trigger pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) cat_cnt_reg <= '0;
    else          cat_cnt_reg <= (state_reg == S_CATEG) ? cat_cnt_reg + CAT_W'(1) : '0;
  end
`endif

  // Binarize the incoming pixel; once underrun, the analyzer only sees zeros.
  assign stream_bit = ((i_pix_luma >= thr_reg) ^ inv_reg) & i_pix_valid & ~underrun_reg;

  // Run configuration, stream flags and the sticky error code.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      thr_reg      <= '0;
      inv_reg      <= 1'b0;
      underrun_reg <= 1'b0;
      seq_reg      <= 1'b0;
      err_reg      <= ERR_NONE;
    end else begin
      seq_reg <= (state_reg == S_STREAM) & stream_bit;
      if (start_acc) begin
        thr_reg      <= i_thresh;
        inv_reg      <= i_invert;
        underrun_reg <= 1'b0;
        err_reg      <= ERR_NONE;
      end else if (timeout) begin
        err_reg <= ERR_TIMEOUT;
      end else if (state_reg == S_STREAM && !i_pix_valid) begin
        underrun_reg <= 1'b1;
        err_reg      <= ERR_UNDERRUN;
      end
    end
  end

  // Result latch; validity drops on a new run or when a run times out.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count_reg        <= '0;
      bigger_reg       <= '0;
      smaller_reg      <= '0;
      result_valid_reg <= 1'b0;
    end else begin
      if (start_acc || timeout) begin
        result_valid_reg <= 1'b0;
      end else if (latch_en) begin
        count_reg        <= i_blob_count;
`ifdef BLOB_CATEG_EN
        bigger_reg       <= i_blob_bigger;
        smaller_reg      <= i_blob_smaller;
`endif
        result_valid_reg <= 1'b1;
      end
    end
  end

  assign o_busy         = (state_reg != S_IDLE);
  assign o_rd_req       = (state_reg == S_STREAM);
  assign o_blob_valid   = o_busy && (state_reg != S_RELEASE);
  assign o_blob_seq     = seq_reg;
`ifdef BLOB_CATEG_EN
  assign o_blob_switch  = (state_reg == S_CATEG) && (cat_cnt_reg == '0);
`else
  assign o_blob_switch  = 1'b0;
`endif
  assign o_count        = count_reg;
  assign o_bigger       = bigger_reg;
  assign o_smaller      = smaller_reg;
  assign o_result_valid = result_valid_reg;
  assign o_err          = err_reg;

endmodule
